// File: rtl/rr_resource_arbiter_pkg.sv
// Shared types for the round-robin resource arbiter.
package rr_resource_arbiter_pkg;

   // Arbiter FSM encoding: one idle state, one holding state.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Requester index that holds top priority out of reset.
   localparam int unsigned PTR_RESET_IDX = 0;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above the one-hot
// pointer, wrapping to the lowest set request when none lie above it.
module rr_priority_pick
   import rr_resource_arbiter_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned OWNER_W = 2
) (
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ-1:0]    i_pointer,
   output logic [NREQ-1:0]    o_pick,
   output logic [OWNER_W-1:0] o_idx,
   output logic               o_valid
);

   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   logic [NREQ-1:0] w_mask;
   logic [NREQ-1:0] w_hi;
   logic [NREQ-1:0] w_src;

   // Mask off requesters below the pointer, fall back to the full vector on
   // wrap, then isolate the lowest set bit (x & -x) and encode it.
   always_comb begin
      w_mask  = ~(i_pointer - ONE);
      w_hi    = i_req & w_mask;
      w_src   = (|w_hi) ? w_hi : i_req;
      o_pick  = w_src & (~w_src + ONE);
      o_valid = |i_req;
      o_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (o_pick[i]) o_idx = OWNER_W'(i);
      end
   end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource between NREQ requesters. A grant
// is held until the owner signals done, drops its request, or has held for
// MAX_HOLD cycles; the priority pointer then moves one past the released owner.
module rr_resource_arbiter
   import rr_resource_arbiter_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned OWNER_W  = 2,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned HOLD_W   = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ-1:0]    i_done,
   output logic [NREQ-1:0]    o_grant,
   output logic [OWNER_W-1:0] o_owner,
   output logic               o_busy,
   output logic [NREQ-1:0]    o_pointer,
   output logic               o_timeout
);

   localparam logic [NREQ-1:0] PTR_RESET = NREQ'(1) << PTR_RESET_IDX;

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [NREQ-1:0]     r_grant,   w_grant_nxt;
   logic [OWNER_W-1:0]  r_owner,   w_owner_nxt;
   logic [NREQ-1:0]     r_pointer, w_pointer_nxt;
   logic [HOLD_W-1:0]   r_hold,    w_hold_nxt;
   logic                r_timeout, w_timeout_nxt;

   logic [NREQ-1:0]     w_pick;
   logic [OWNER_W-1:0]  w_pick_idx;
   logic                w_pick_vld;
   logic                w_own_done;
   logic                w_own_req;
   logic                w_hold_max;
   logic                w_release;

   rr_priority_pick #(
      .NREQ    (NREQ),
      .OWNER_W (OWNER_W)
   ) u_pick (
      .i_req     (i_req),
      .i_pointer (r_pointer),
      .o_pick    (w_pick),
      .o_idx     (w_pick_idx),
      .o_valid   (w_pick_vld)
   );

   // Release conditions, all qualified by the current one-hot grant so that
   // done/req bits of non-owners never matter.
   always_comb begin
      w_own_done = |(i_done & r_grant);
      w_own_req  = |(i_req & r_grant);
      w_hold_max = (r_hold == HOLD_W'(MAX_HOLD));
      w_release  = w_own_done | ~w_own_req | w_hold_max;
   end

   // Next-state and next-output logic; timeout flags only a pure hold-limit release.
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_owner_nxt   = r_owner;
      w_pointer_nxt = r_pointer;
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_grant_nxt = w_pick;
               w_owner_nxt = w_pick_idx;
               w_hold_nxt  = HOLD_W'(1);
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_grant_nxt   = '0;
               w_pointer_nxt = {r_grant[NREQ-2:0], r_grant[NREQ-1]};
               w_hold_nxt    = '0;
               w_timeout_nxt = w_hold_max & ~w_own_done & w_own_req;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_hold_nxt = r_hold + HOLD_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_pointer <= PTR_RESET;
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_owner   <= w_owner_nxt;
         r_pointer <= w_pointer_nxt;
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign o_grant   = r_grant;
   assign o_owner   = r_owner;
   assign o_busy    = |r_grant;
   assign o_pointer = r_pointer;
   assign o_timeout = r_timeout;

endmodule
